// File: rtl/layer5_pkg.sv
// Shared constants, weight/bias tables and FSM encodings for the layer-5 serial classifier.
package layer5_pkg;

   localparam int unsigned N_IN  = 16;
   localparam int unsigned N_OUT = 5;
   localparam int unsigned FRAC  = 6;
   localparam int unsigned ACC_W = 23;
   localparam int unsigned ID_W  = $clog2(N_OUT);
   localparam int unsigned IDX_W = $clog2(N_IN);

   typedef logic [N_OUT-1:0][N_IN-1:0][7:0] wgt_t;
   typedef logic [N_OUT-1:0][15:0]          bias_t;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_MAC  = 2'd1;
   localparam logic [1:0] ST_FIN  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   // Class o responds to activation 0 with weight o+1; everything else is zero.
   function automatic wgt_t default_w();
      wgt_t w;
      w = '0;
      for (int unsigned o = 0; o < N_OUT; o++) begin
         w[o][0] = 8'(o + 1);
      end
      return w;
   endfunction

   localparam wgt_t  W = default_w();
   localparam bias_t B = '0;

endpackage

// File: rtl/requant_sat.sv
// Signed accumulator to 8-bit requantiser: arithmetic shift, round up above one half, saturate.
module requant_sat #(
   parameter int unsigned IN_W = 23,
   parameter int unsigned FRAC = 6
) (
   input  logic signed [IN_W-1:0] s,
   output logic signed [7:0]      q_c
);

   localparam logic signed [IN_W-1:0] Q_MAX = IN_W'(127);
   localparam logic signed [IN_W-1:0] Q_MIN = IN_W'(-128);

   logic signed [IN_W-1:0] shifted;
   logic signed [IN_W-1:0] rounded;
   logic                   rnd;

   // Exactly one half is not rounded up; only a strictly larger fraction carries.
   always_comb begin
      shifted = s >>> FRAC;
      rnd     = s[FRAC-1] & (|s[FRAC-2:0]);
      rounded = rnd ? shifted + IN_W'(1) : shifted;
      if (rounded > Q_MAX) begin
         q_c = 8'h7F;
      end else if (rounded < Q_MIN) begin
         q_c = 8'h80;
      end else begin
         q_c = rounded[7:0];
      end
   end

endmodule

// File: rtl/layer5_serial_classifier.sv
// Layer-5 output stage: latches one activation frame, scores each class on a shared MAC,
// requantises the scores and reports the argmax over a valid/ready handshake.
module layer5_serial_classifier
   import layer5_pkg::*;
#(
   parameter wgt_t  WGT  = W,
   parameter bias_t BIAS = B
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [N_IN*8-1:0]       act_flat,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [ID_W-1:0]         class_id,
   output logic signed [7:0]       class_score
);

   logic [1:0]               state;
   logic [1:0]               state_nx;
   logic [ID_W-1:0]          o_cnt;
   logic [IDX_W-1:0]         i_cnt;
   logic [N_IN-1:0][7:0]     act_q;
   logic signed [ACC_W-1:0]  acc;
   logic signed [ACC_W-1:0]  sum_c;
   logic signed [15:0]       prod_c;
   logic signed [7:0]        q_c;
   logic signed [7:0]        best_score;
   logic [ID_W-1:0]          best_id;
   logic signed [7:0]        cand_score_c;
   logic [ID_W-1:0]          cand_id_c;
   logic                     take_c;
   logic                     last_i_c;
   logic                     last_o_c;

   assign last_i_c = (i_cnt == IDX_W'(N_IN - 1));
   assign last_o_c = (o_cnt == ID_W'(N_OUT - 1));

   always_comb begin
      state_nx = state;
      unique case (state)
         ST_IDLE: if (in_valid)  state_nx = ST_MAC;
         ST_MAC:  if (last_i_c)  state_nx = ST_FIN;
         ST_FIN:  state_nx = last_o_c ? ST_DONE : ST_MAC;
         ST_DONE: if (out_ready) state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   // Shared MAC datapath, bias add and running argmax (ties keep the lower index).
   always_comb begin
      prod_c       = 16'($signed(act_q[i_cnt])) * 16'($signed(WGT[o_cnt][i_cnt]));
      sum_c        = acc + ACC_W'($signed(BIAS[o_cnt]));
      take_c       = (o_cnt == '0) || (q_c > best_score);
      cand_score_c = take_c ? q_c : best_score;
      cand_id_c    = take_c ? o_cnt : best_id;
   end

   requant_sat #(
      .IN_W (ACC_W),
      .FRAC (FRAC)
   ) u_requant (
      .s   (sum_c),
      .q_c (q_c)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= ST_IDLE;
         in_ready    <= 1'b1;
         out_valid   <= 1'b0;
         o_cnt       <= '0;
         i_cnt       <= '0;
         act_q       <= '0;
         acc         <= '0;
         best_score  <= '0;
         best_id     <= '0;
         class_id    <= '0;
         class_score <= '0;
      end else begin
         state     <= state_nx;
         in_ready  <= (state_nx == ST_IDLE);
         out_valid <= (state_nx == ST_DONE);
         if ((state == ST_IDLE) && in_valid) begin
            act_q <= act_flat;
            acc   <= '0;
            i_cnt <= '0;
            o_cnt <= '0;
         end
         if (state == ST_MAC) begin
            acc   <= acc + ACC_W'(prod_c);
            i_cnt <= last_i_c ? '0 : i_cnt + IDX_W'(1);
         end
         if (state == ST_FIN) begin
            acc        <= '0;
            best_score <= cand_score_c;
            best_id    <= cand_id_c;
            o_cnt      <= last_o_c ? '0 : o_cnt + ID_W'(1);
            if (last_o_c) begin
               class_id    <= cand_id_c;
               class_score <= cand_score_c;
            end
         end
      end
   end

endmodule

// File: tb/tb_layer5_serial_classifier.sv
// Bench for layer5_serial_classifier: four weight sets share one stimulus stream and are
// checked every cycle against a frame-level reference model.
module tb_layer5_serial_classifier;
   import layer5_pkg::*;

   localparam int LAT = N_OUT * (N_IN + 1);
   localparam int ND  = 4;

   typedef struct packed {
      int id;
      int sc;
   } res_t;

   function automatic wgt_t tie_w();
      wgt_t w;
      w = '0;
      for (int o = 0; o < N_OUT; o++) w[o][0] = 8'd1;
      return w;
   endfunction

   function automatic wgt_t sat_w();
      wgt_t w;
      w = '0;
      w[0][0] = 8'd127;
      return w;
   endfunction

   function automatic wgt_t mix_w();
      wgt_t w;
      for (int o = 0; o < N_OUT; o++)
         for (int i = 0; i < N_IN; i++)
            w[o][i] = 8'(((o * 7 + i * 5) % 19) - 9);
      return w;
   endfunction

   function automatic bias_t mix_b();
      bias_t b;
      for (int o = 0; o < N_OUT; o++) b[o] = 16'(o * 250 - 500);
      return b;
   endfunction

   localparam wgt_t  W_TIE = tie_w();
   localparam wgt_t  W_SAT = sat_w();
   localparam wgt_t  W_MIX = mix_w();
   localparam bias_t B_MIX = mix_b();
   localparam bias_t B_ZERO = '0;

   logic                clk = 1'b0;
   logic                reset;
   logic                in_valid;
   logic                out_ready;
   logic [N_IN*8-1:0]   act_flat;
   logic                rdy [ND];
   logic                ov  [ND];
   logic [ID_W-1:0]     cid [ND];
   logic [7:0]          csc [ND];

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   layer5_serial_classifier #(.WGT(W), .BIAS(B)) u_def (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[0]), .act_flat(act_flat),
      .out_valid(ov[0]), .out_ready(out_ready), .class_id(cid[0]), .class_score(csc[0]));
   layer5_serial_classifier #(.WGT(W_TIE), .BIAS(B_ZERO)) u_tie (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[1]), .act_flat(act_flat),
      .out_valid(ov[1]), .out_ready(out_ready), .class_id(cid[1]), .class_score(csc[1]));
   layer5_serial_classifier #(.WGT(W_SAT), .BIAS(B_ZERO)) u_sat (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[2]), .act_flat(act_flat),
      .out_valid(ov[2]), .out_ready(out_ready), .class_id(cid[2]), .class_score(csc[2]));
   layer5_serial_classifier #(.WGT(W_MIX), .BIAS(B_MIX)) u_mix (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[3]), .act_flat(act_flat),
      .out_valid(ov[3]), .out_ready(out_ready), .class_id(cid[3]), .class_score(csc[3]));

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Frame-level reference: integer dot products, floor divide, round above one half, clamp.
   function automatic res_t model(input wgt_t w, input bias_t b, input logic [N_IN*8-1:0] a);
      res_t res;
      int   s, r, frac, one;
      one = 1 << FRAC;
      res.id = 0;
      res.sc = 0;
      for (int o = 0; o < N_OUT; o++) begin
         s = int'($signed(b[o]));
         for (int i = 0; i < N_IN; i++)
            s += int'($signed(a[8*i +: 8])) * int'($signed(w[o][i]));
         if (s >= 0) r = s / one;
         else        r = -((-s + one - 1) / one);
         frac = s - r * one;
         if (frac > one / 2) r++;
         if (r > 127)  r = 127;
         if (r < -128) r = -128;
         if (o == 0 || r > res.sc) begin
            res.id = o;
            res.sc = r;
         end
      end
      return res;
   endfunction

   int   m_cnt  = 0;
   logic m_done = 1'b0;
   res_t exp_r [ND];
   res_t pend  [ND];

   initial begin
      for (int k = 0; k < ND; k++) begin
         exp_r[k] = '0;
         pend[k]  = '0;
      end
   end

   // Reference timing: a frame accepted when idle yields its result LAT edges later.
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_cnt  <= 0;
         m_done <= 1'b0;
         for (int k = 0; k < ND; k++) exp_r[k] <= '0;
      end else if (m_cnt > 0) begin
         m_cnt <= m_cnt - 1;
         if (m_cnt == 1) begin
            m_done <= 1'b1;
            for (int k = 0; k < ND; k++) exp_r[k] <= pend[k];
         end
      end else if (m_done) begin
         if (out_ready) m_done <= 1'b0;
      end else if (in_valid) begin
         m_cnt   <= LAT;
         pend[0] <= model(W, B, act_flat);
         pend[1] <= model(W_TIE, B_ZERO, act_flat);
         pend[2] <= model(W_SAT, B_ZERO, act_flat);
         pend[3] <= model(W_MIX, B_MIX, act_flat);
      end
   end

   always @(negedge clk) begin
      for (int k = 0; k < ND; k++) begin
         chk($sformatf("in_ready[%0d]", k), int'(rdy[k]), int'(m_cnt == 0 && !m_done));
         chk($sformatf("out_valid[%0d]", k), int'(ov[k]), int'(m_done));
         chk($sformatf("class_id[%0d]", k), int'(cid[k]), exp_r[k].id);
         chk($sformatf("class_score[%0d]", k), int'($signed(csc[k])), exp_r[k].sc);
      end
   end

   function automatic logic [N_IN*8-1:0] byte0(input logic [7:0] v);
      logic [N_IN*8-1:0] a;
      a = '0;
      a[7:0] = v;
      return a;
   endfunction

   function automatic logic [N_IN*8-1:0] rand_act();
      logic [N_IN*8-1:0] a;
      for (int i = 0; i < N_IN; i++) a[8*i +: 8] = 8'($urandom);
      return a;
   endfunction

   task automatic wait_ready();
      int t;
      t = 0;
      while (rdy[0] !== 1'b1 && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (t >= 300) chk("in_ready_timeout", 0, 1);
   endtask

   task automatic run_frame(input logic [N_IN*8-1:0] a, input int hold, input bit noise);
      int t;
      wait_ready();
      in_valid = 1'b1;
      act_flat = a;
      @(negedge clk);
      in_valid = 1'b0;
      act_flat = rand_act();
      t = 0;
      while (ov[0] !== 1'b1 && t < 300) begin
         @(negedge clk);
         t++;
         if (noise && t >= 10 && t < 15) begin
            in_valid = 1'b1;
            act_flat = rand_act();
         end else begin
            in_valid = 1'b0;
         end
      end
      chk("latency", t, LAT);
      repeat (hold) @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   initial begin
      int cyc, last_rise;
      bit seen, prev;
      reset     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      act_flat  = '0;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", int'(rdy[0]), 1);
      chk("rst_out_valid", int'(ov[0]), 0);
      chk("rst_class_id", int'(cid[0]), 0);
      chk("rst_class_score", int'($signed(csc[0])), 0);
      #2 reset = 1'b1;
      @(negedge clk);

      run_frame(byte0(8'd64), 10, 1'b0);
      chk("argmax_id", int'(cid[0]), 4);
      chk("argmax_score", int'($signed(csc[0])), 5);
      chk("tie64_id", int'(cid[1]), 0);
      chk("tie64_score", int'($signed(csc[1])), 1);

      run_frame(byte0(8'd96), 0, 1'b1);
      chk("def96_score", int'($signed(csc[0])), 7);
      chk("half_round_score", int'($signed(csc[1])), 1);

      run_frame(byte0(8'd97), 3, 1'b0);
      chk("above_half_score", int'($signed(csc[1])), 2);
      chk("sat97_score", int'($signed(csc[2])), 127);

      run_frame(rand_act(), 0, 1'b0);

      // Abort a frame part-way through MAC.
      wait_ready();
      in_valid = 1'b1;
      act_flat = rand_act();
      @(negedge clk);
      in_valid = 1'b0;
      repeat (39) @(negedge clk);
      #2 reset = 1'b0;
      @(negedge clk);
      chk("abort_in_ready", int'(rdy[0]), 1);
      chk("abort_out_valid", int'(ov[0]), 0);
      chk("abort_class_score", int'($signed(csc[0])), 0);
      #2 reset = 1'b1;
      @(negedge clk);

      run_frame(byte0(8'd127), 0, 1'b0);
      chk("possat_id", int'(cid[2]), 0);
      chk("possat_score", int'($signed(csc[2])), 127);
      chk("def127_score", int'($signed(csc[0])), 10);
      chk("tie127_score", int'($signed(csc[1])), 2);

      run_frame(byte0(8'h80), 0, 1'b0);
      chk("negsat_id", int'(cid[2]), 1);
      chk("negsat_score", int'($signed(csc[2])), 0);
      chk("defneg_id", int'(cid[0]), 0);
      chk("defneg_score", int'($signed(csc[0])), -2);

      run_frame(rand_act(), 2, 1'b0);

      // Back-to-back frames with the consumer always ready.
      wait_ready();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      act_flat  = rand_act();
      seen = 1'b0;
      prev = 1'b0;
      last_rise = 0;
      for (cyc = 0; cyc < 200; cyc++) begin
         @(negedge clk);
         if (ov[0] && !prev) begin
            if (seen) chk("throughput", cyc - last_rise, LAT + 2);
            last_rise = cyc;
            seen = 1'b1;
         end
         prev = ov[0];
      end
      in_valid = 1'b0;
      repeat (LAT + 10) @(negedge clk);
      out_ready = 1'b0;
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/layer5_serial_classifier.md
# layer5_serial_classifier

Output stage placed directly downstream of the layer-4 neuron nodes. It captures one frame of N_IN parallel 8-bit layer-4 activations and evaluates N_OUT output neurons on a single time-multiplexed multiply-accumulate unit. Each output score is requantised to 8 bits, and a running argmax selects the winning class. The result goes out on a valid/ready handshake.

## Interface
- N_IN, 16: number of layer-4 activations per frame.
- N_OUT, 5: number of output classes.
- FRAC, 6: fractional bits dropped during requantisation.
- ACC_W, 23: accumulator width, signed.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  activation frame present.
- in_ready  out  1  block can accept a frame; high only in IDLE.
- act_flat  in  N_IN*8  activations; act[i] = act_flat[8i+7:8i], signed 8-bit.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accepts the result.
- class_id  out  $clog2(N_OUT)  index of the winning class.
- class_score  out  8  requantised score of the winner, signed.

## Operation
- States and transitions:
  - IDLE: go to MAC on in_valid && in_ready; all N_IN activations are latched into a register bank on that edge.
  - MAC: one product per cycle; acc += act[i]*W[o][i], with i running 0..N_IN-1 for each output o. Products are 16-bit signed and sign-extended to ACC_W. acc is cleared at the start of each o.
  - FIN, one cycle per o:
    - s = acc + sign-extended B[o].
    - r = s >>> FRAC (arithmetic shift).
    - r += 1 when s[FRAC-1]==1 and s[FRAC-2:0]!=0.
    - Saturate r to [-128, 127]; a rounding carry past 127 also saturates.
    - Comparison: o==0 loads best; for o>0, best is replaced only when r > best (strictly greater), so ties keep the lower index.
    - Next state: MAC with o+1, or DONE after o==N_OUT-1.
  - DONE: out_valid=1; class_id and class_score are stable. On out_ready, go to IDLE.
- Flow control: in_valid is ignored outside IDLE. Frames are never dropped silently, because the upstream must hold in_valid until in_ready is high.
- Weights W[o][i] (signed 8-bit) and biases B[o] (signed 16-bit, at product scale) are compile-time constants.
- There is no ReLU on this stage; negative scores are kept.

## Timing
- Reset (reset==0, asynchronous):
  - State goes to IDLE; counters, acc, best and the activation bank are cleared.
  - Outputs: in_ready=1, out_valid=0, class_id=0, class_score=0.
- Latency: out_valid rises N_OUT*(N_IN+1) cycles after the accepting edge; 85 cycles with the defaults.
- Throughput: one frame per N_OUT*(N_IN+1)+2 cycles when out_ready is held high.
- DONE with out_ready=1: IDLE is entered on the next edge. in_ready rises that cycle; a frame is never accepted in the same cycle as the result hand-off.
- Reset asserted mid-frame aborts immediately. No partial result is ever presented.
- class_id and class_score update only on DONE entry and hold until the next DONE entry.

## Structure
- Package layer5_pkg holds:
  - N_IN, N_OUT, FRAC;
  - weight array W[N_OUT][N_IN] and bias array B[N_OUT];
  - FSM state enum {IDLE, MAC, FIN, DONE}.
- One sub-module, requant_sat: combinational ACC_W-bit to 8-bit round and saturate, parameterised on FRAC. It is reusable by other serial layers.

## Test plan
Benches build with test constants W[o][0]=o+1, all other weights 0, and B=0 unless a scenario says otherwise.
- Argmax: act[0]=64, others 0 -> scores 1..5; class_id=4 and class_score=5 at cycle 85 after acceptance.
- Ties: all W[o][0]=1 and act[0]=64 -> every score is 1; class_id=0, class_score=1.
- Rounding: with W[0][0]=1, act[0]=96 gives acc=96 -> score 1; act[0]=97 -> score 2. act[0]=127 with W[0][0]=127 gives 16129 -> score 127 (saturated).
- Negative saturation: act[0]=8'h80 with W[0][0]=127 gives -16256 -> score -128. All other scores are 0, so class_id selects the first class with score 0.
- Handshake and reset:
  - Hold out_ready=0 for 10 cycles: out_valid and the outputs stay stable.
  - A new in_valid during MAC is ignored.
  - Pulse reset low at cycle 40 of a frame: next cycle in_ready=1 and out_valid=0; a following frame completes correctly.
